// File: rtl/color_mask_window_gen.sv
// Streams a raster of masked pixels through line buffers and a column shift
// register, emitting one zero-padded N_SIZE x N_SIZE window per image pixel.
module color_mask_window_gen #(
  parameter int N_SIZE     = 5,
  parameter int COLORS     = 2,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLORS:0]   in_pixel,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [COLORS:0]   out_window [0:N_SIZE-1][0:N_SIZE-1],
  output logic              out_valid,
  output logic              out_eof
);

  localparam int K  = N_SIZE / 2;
  localparam int CW = $clog2(IMG_WIDTH + K);
  localparam int RW = $clog2(IMG_HEIGHT + K);
  localparam int LW = $clog2(IMG_WIDTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH + K - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_W    = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_K    = CW'(K);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT + K - 1);
  localparam logic [RW-1:0] ROW_HM1  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K);

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_PAD, S_FLUSH} state_t;

  state_t            state_r;
  logic [CW-1:0]     wr_col_r;
  logic [RW-1:0]     wr_row_r;
  logic              in_ready_r;

  logic [COLORS:0]   lb_r      [0:N_SIZE-2][0:IMG_WIDTH-1];
  logic [COLORS:0]   sr_r      [0:N_SIZE-1][0:N_SIZE-1];
  logic [COLORS:0]   sr_next_s [0:N_SIZE-1][0:N_SIZE-1];
  logic [COLORS:0]   win_s     [0:N_SIZE-1][0:N_SIZE-1];
  logic [COLORS:0]   col_s     [0:N_SIZE-1];
  logic [N_SIZE-1:0] row_ok_s;
  logic [N_SIZE-1:0] col_ok_s;
  logic [COLORS:0]   pix_s;
  logic              step_s;
  logic              lb_hit_s;
  logic [LW-1:0]     lb_idx_s;

  assign in_ready = in_ready_r;
  assign lb_hit_s = (wr_col_r < COL_W);
  assign lb_idx_s = wr_col_r[LW-1:0];

  // Decide whether this cycle is a pipeline step and which pixel it carries.
  always_comb begin
    step_s = 1'b0;
    pix_s  = '0;
    case (state_r)
      S_IDLE: begin
        step_s = in_valid && in_ready_r && in_sof;
        pix_s  = in_pixel;
      end
      S_ROW: begin
        step_s = in_valid && in_ready_r;
        pix_s  = in_pixel;
      end
      S_PAD, S_FLUSH: begin
        step_s = 1'b1;
        pix_s  = '0;
      end
      default: begin
        step_s = 1'b0;
        pix_s  = '0;
      end
    endcase
  end

  // Build the incoming column, the shifted register image and the masked window.
  always_comb begin
    for (int i = 0; i < N_SIZE - 1; i++) begin
      if (lb_hit_s) begin
        col_s[i] = lb_r[N_SIZE-2-i][lb_idx_s];
      end else begin
        col_s[i] = '0;
      end
    end
    col_s[N_SIZE-1] = pix_s;
    for (int i = 0; i < N_SIZE; i++) begin
      row_ok_s[i] = (int'(wr_row_r) + i >= N_SIZE - 1) &&
                    (int'(wr_row_r) + i <= IMG_HEIGHT + N_SIZE - 2);
      col_ok_s[i] = (int'(wr_col_r) + i >= N_SIZE - 1) &&
                    (int'(wr_col_r) + i <= IMG_WIDTH + N_SIZE - 2);
    end
    for (int i = 0; i < N_SIZE; i++) begin
      for (int j = 0; j < N_SIZE; j++) begin
        if (j < N_SIZE - 1) begin
          sr_next_s[i][j] = sr_r[i][j+1];
        end else begin
          sr_next_s[i][j] = col_s[i];
        end
        // Elements outside the image are forced to zero, which also hides stale buffer data.
        if (row_ok_s[i] && col_ok_s[j]) begin
          win_s[i][j] = sr_next_s[i][j];
        end else begin
          win_s[i][j] = '0;
        end
      end
    end
  end

  // Line buffers age one row per step; contents need no reset.
  always_ff @(posedge clk) begin
    if (step_s && lb_hit_s) begin
      lb_r[0][lb_idx_s] <= pix_s;
      for (int m = 1; m < N_SIZE - 1; m++) begin
        lb_r[m][lb_idx_s] <= lb_r[m-1][lb_idx_s];
      end
    end
  end

  // Sequencer, step counters, shift register and registered window outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wr_col_r   <= '0;
      wr_row_r   <= '0;
      in_ready_r <= 1'b0;
      out_valid  <= 1'b0;
      out_eof    <= 1'b0;
      for (int i = 0; i < N_SIZE; i++) begin
        for (int j = 0; j < N_SIZE; j++) begin
          sr_r[i][j]       <= '0;
          out_window[i][j] <= '0;
        end
      end
    end else begin
      out_valid <= step_s && (wr_row_r >= ROW_K) && (wr_col_r >= COL_K);
      out_eof   <= step_s && (wr_row_r == ROW_LAST) && (wr_col_r == COL_LAST);
      if (state_r == S_IDLE) begin
        in_ready_r <= 1'b1;
      end
      if (step_s) begin
        sr_r       <= sr_next_s;
        out_window <= win_s;
        case (state_r)
          S_IDLE: begin
            state_r  <= S_ROW;
            wr_col_r <= wr_col_r + CW'(1);
          end
          S_ROW: begin
            wr_col_r <= wr_col_r + CW'(1);
            if (wr_col_r == COL_EDGE) begin
              state_r    <= S_PAD;
              in_ready_r <= 1'b0;
            end
          end
          S_PAD: begin
            if (wr_col_r == COL_LAST) begin
              wr_col_r <= '0;
              wr_row_r <= wr_row_r + RW'(1);
              if (wr_row_r < ROW_HM1) begin
                state_r    <= S_ROW;
                in_ready_r <= 1'b1;
              end else begin
                state_r <= S_FLUSH;
              end
            end else begin
              wr_col_r <= wr_col_r + CW'(1);
            end
          end
          S_FLUSH: begin
            if (wr_col_r == COL_LAST) begin
              wr_col_r <= '0;
              if (wr_row_r == ROW_LAST) begin
                wr_row_r   <= '0;
                state_r    <= S_IDLE;
                in_ready_r <= 1'b1;
              end else begin
                wr_row_r <= wr_row_r + RW'(1);
              end
            end else begin
              wr_col_r <= wr_col_r + CW'(1);
            end
          end
          default: begin
            state_r  <= S_IDLE;
            wr_col_r <= '0;
            wr_row_r <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_mask_window_gen.sv
// Directed bench for color_mask_window_gen with a 3x3 window on a 4x3 image.
module tb_color_mask_window_gen;

  localparam int N = 3;
  localparam int W = 4;
  localparam int H = 3;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [C:0]   in_pixel;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [C:0]   out_window [0:N-1][0:N-1];
  logic         out_valid;
  logic         out_eof;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           ready_low = 0;
  logic [27:0]  win_q [$];
  logic [2:0]   img [0:1][0:H-1][0:W-1];

  color_mask_window_gen #(.N_SIZE(N), .COLORS(C), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_window(out_window), .out_valid(out_valid), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] flat_obs();
    logic [26:0] f;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        f[(i*N+j)*3 +: 3] = out_window[i][j];
    return f;
  endfunction

  // Reference neighborhood of window k taken straight from the source image.
  function automatic logic [26:0] exp_win(input int sel, input int k);
    logic [26:0] f;
    int r, c, rr, cc;
    r = k / W;
    c = k % W;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) f[(i*N+j)*3 +: 3] = img[sel][rr][cc];
        else f[(i*N+j)*3 +: 3] = 3'b000;
      end
    return f;
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) win_q.push_back({out_eof, flat_obs()});
    if (reset === 1'b0 && in_ready === 1'b0) ready_low++;
  end

  task automatic drive_px(input logic [2:0] p, input logic sof);
    int n;
    n = 0;
    in_pixel = p;
    in_sof   = sof;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_bad++;
      $display("FAIL drive_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int maxgap, input int npix);
    for (int k = 0; k < npix; k++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      drive_px(img[sel][k/W][k%W], k == 0);
    end
  endtask

  task automatic wait_windows(input int n);
    int t;
    t = 0;
    while (win_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 3'b000;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (out_eof !== 1'b0) begin n_bad++; $display("FAIL rst_out_eof: got %b expected 0", out_eof); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    if (flat_obs() !== 27'd0) begin n_bad++; $display("FAIL rst_window: got %h expected 0", flat_obs()); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_pre_sof();
    for (int k = 0; k < 3; k++) drive_px(3'b111, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (win_q.size() != 0) begin n_bad++; $display("FAIL presof_drop: got %0d windows expected 0", win_q.size()); end
    win_q.delete();
    ready_low = 0;
    for (int k = 0; k < W*H; k++) begin
      drive_px(img[0][k/W][k%W], k == 0);
      if (k == 4 || k == 5) begin
        @(negedge clk);
        n_cmp++;
        if (win_q.size() != k - 4) begin
          n_bad++;
          $display("FAIL first_window_k%0d: got %0d windows expected %0d", k, win_q.size(), k - 4);
        end
      end
    end
    wait_windows(12);
    n_cmp += 3;
    if (win_q.size() != 12) begin n_bad++; $display("FAIL basic_count: got %0d expected 12", win_q.size()); end
    if (ready_low != 8) begin n_bad++; $display("FAIL basic_ready_low: got %0d expected 8", ready_low); end
    if (win_q.size() >= 12 && (win_q[0] !== {1'b0, 27'b101_100_000_101_100_000_000_000_000} ||
        win_q[11] !== {1'b1, 27'b000_000_000_000_111_110_000_111_110})) begin
      n_bad++;
      $display("FAIL basic_hand_corners: got %h / %h", win_q[0], win_q[11]);
    end
    for (int k = 0; k < win_q.size() && k < 12; k++) begin
      n_cmp++;
      if (win_q[k] !== {k == 11, exp_win(0, k)}) begin
        n_bad++;
        $display("FAIL basic_win%0d: got %h expected %h", k, win_q[k], {k == 11, exp_win(0, k)});
      end
    end
  endtask

  task automatic test_gaps();
    win_q.delete();
    ready_low = 0;
    send_frame(0, 3, W*H);
    wait_windows(12);
    n_cmp += 2;
    if (win_q.size() != 12) begin n_bad++; $display("FAIL gap_count: got %0d expected 12", win_q.size()); end
    if (ready_low != 8) begin n_bad++; $display("FAIL gap_ready_low: got %0d expected 8", ready_low); end
    for (int k = 0; k < win_q.size() && k < 12; k++) begin
      n_cmp++;
      if (win_q[k] !== {k == 11, exp_win(0, k)}) begin
        n_bad++;
        $display("FAIL gap_win%0d: got %h expected %h", k, win_q[k], {k == 11, exp_win(0, k)});
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(0, 0, 6);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    win_q.delete();
    reset = 1'b0;
    @(negedge clk);
    send_frame(1, 1, W*H);
    wait_windows(12);
    n_cmp++;
    if (win_q.size() != 12) begin n_bad++; $display("FAIL mid_count: got %0d expected 12", win_q.size()); end
    for (int k = 0; k < win_q.size() && k < 12; k++) begin
      n_cmp++;
      if (win_q[k] !== {k == 11, exp_win(1, k)}) begin
        n_bad++;
        $display("FAIL mid_win%0d: got %h expected %h", k, win_q[k], {k == 11, exp_win(1, k)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int eofs;
    win_q.delete();
    send_frame(0, 0, W*H);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_held: got in_ready=%b expected 0", in_ready); end
    send_frame(1, 0, W*H);
    wait_windows(24);
    n_cmp += 2;
    if (win_q.size() != 24) begin n_bad++; $display("FAIL b2b_count: got %0d expected 24", win_q.size()); end
    eofs = 0;
    for (int k = 0; k < win_q.size(); k++) eofs += int'(win_q[k][27]);
    if (eofs != 2) begin n_bad++; $display("FAIL b2b_eofs: got %0d expected 2", eofs); end
    for (int k = 0; k < win_q.size() && k < 24; k++) begin
      n_cmp++;
      if (win_q[k] !== {k % 12 == 11, exp_win(k / 12, k % 12)}) begin
        n_bad++;
        $display("FAIL b2b_win%0d: got %h expected %h", k, win_q[k], {k % 12 == 11, exp_win(k / 12, k % 12)});
      end
    end
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[0][r][c] = {1'b1, 2'((r*W + c) % 4)};
        img[1][r][c] = {1'((r + c) % 2), 2'((r*W + c + 2) % 4)};
      end
    reset = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pixel = 3'b000;
    @(negedge clk);
    test_reset();
    test_pre_sof();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/color_mask_window_gen.md
COLOR_MASK_WINDOW_GEN -- requirements
Module: color_mask_window_gen

Interface
REQ-001 The block SHALL have parameter N_SIZE, default 5: window edge, odd, >=3; K = N_SIZE/2.
REQ-002 The block SHALL have parameter COLORS, default 2: pixel bit COLORS is the pixel-valid flag; bits COLORS-1..0 are the color-mask flags.
REQ-003 The block SHALL have parameter IMG_WIDTH, default 640: pixels per row, W > N_SIZE.
REQ-004 The block SHALL have parameter IMG_HEIGHT, default 480: rows per frame, H > N_SIZE.
REQ-005 The block SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have port in_pixel  in  COLORS+1  raster-order masked pixel.
REQ-008 The block SHALL have port in_valid  in  1  in_pixel present this cycle.
REQ-009 The block SHALL have port in_sof  in  1  in_pixel is row 0, col 0 of a frame.
REQ-010 The block SHALL have port in_ready  out  1  block accepts in_pixel this cycle.
REQ-011 The block SHALL have port out_window  out  [COLORS:0] x [0:N_SIZE-1][0:N_SIZE-1]  NxN neighborhood, [i][j] = row offset i-K, column offset j-K from the center.
REQ-012 The block SHALL have port out_valid  out  1  out_window valid this cycle.
REQ-013 The block SHALL have port out_eof  out  1  the current window is the last of the frame (center H-1, W-1).

Function
REQ-014 A "step" SHALL be any cycle that advances the pipeline: an accepted pixel (in_valid && in_ready in ROW) or an internally generated all-zero pixel (PAD, FLUSH).
REQ-015 The block SHALL implement states IDLE, ROW, PAD, FLUSH with step counters wr_col in 0..W+K-1 and wr_row in 0..H+K-1.
REQ-016 In IDLE, in_ready SHALL be 1, and pixels without in_sof SHALL be discarded.
REQ-017 An accepted in_sof pixel in IDLE SHALL be step (0,0) and SHALL transition the block to ROW.
REQ-018 ROW SHALL assert in_ready, and after the step at wr_col = W-1 the block SHALL enter PAD.
REQ-019 PAD SHALL deassert in_ready and generate K zero steps (wr_col W..W+K-1); it SHALL then go to ROW if the next wr_row < H, else to FLUSH.
REQ-020 FLUSH SHALL deassert in_ready and generate zero steps for rows H..H+K-1, W+K steps each; after step (H+K-1, W+K-1) the block SHALL return to IDLE.
REQ-021 in_sof asserted outside IDLE SHALL be ignored, and that pixel SHALL be treated as ordinary data.
REQ-022 The block SHALL hold N_SIZE-1 line buffers of W entries each, plus an N_SIZE x N_SIZE column shift register, written once per step.
REQ-023 A step at (wr_row >= K, wr_col >= K) SHALL produce, on the next clock edge, out_valid=1 and a window centered at (wr_row-K, wr_col-K); all other cycles SHALL have out_valid=0.
REQ-024 Each window element whose image coordinate lies outside 0..H-1 or 0..W-1 SHALL be output as all-zero, including its valid bit.
REQ-025 In-range elements SHALL equal the accepted pixel bit-exactly, including a valid bit of 0.
REQ-026 Exactly W*H windows SHALL be emitted per frame, in center raster order, with out_eof=1 only on the last window.
REQ-027 Input stalls (in_valid=0 in ROW) SHALL freeze the counters, the buffers and the shift register, and SHALL deassert out_valid.
REQ-028 Window-to-step latency SHALL be exactly 1 clock, and window content SHALL be independent of stall pattern.

Reset
REQ-029 While reset=1, the state SHALL be IDLE, the counters 0, out_valid=0, out_eof=0, out_window all-zero, and in_ready=0.
REQ-030 Line-buffer contents need not be cleared; REQ-024 masking SHALL make any stale data unobservable.
REQ-031 Reset mid-frame SHALL abandon the frame; the first window after reset SHALL belong to the next in_sof frame.

Verification (N_SIZE=3, W=4, H=3, COLORS=2)
REQ-032 Continuous frame of pixel value 3'b1xx (incrementing color bits) -> 12 windows; window (0,0) row 0 and column 0 all zero; center equals the source pixel; out_eof only on the 12th.
REQ-033 Random in_valid gaps -> window sequence identical to the no-gap run; in_ready=0 for exactly 1 cycle per row (PAD) and for 5 cycles of FLUSH.
REQ-034 Pixels sent before the first in_sof -> dropped; no out_valid until a step with wr_row>=1, wr_col>=1 of the sof frame.
REQ-035 reset pulse after 6 accepted pixels, then a new full frame -> exactly 12 windows with no stale data from the aborted frame.
REQ-036 Back-to-back frames, second in_sof offered while FLUSH -> held (in_ready=0) until IDLE, then accepted; 24 windows total, two out_eof pulses.
